prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream stage of the accumulator core. Receives a framed program image as a byte stream and writes it into the core's 128x8 instruction memory through the core's write port (write enable, 7-bit address, 8-bit data).
- Validates each frame by length and checksum. Raises `core_run` only after a good load, so the core never executes a partial image.
- While loading, its `mem_we` holds the core in write mode, which freezes core execution.

Parameters:
- ADDR_W, 7, instruction memory address width
- DEPTH, 128, instruction memory depth; maximum payload length
- SYNC, 8'hA5, frame start byte
- TIMEOUT, 1000, idle cycles allowed between bytes inside a frame before abort
- TO_W, 10, timeout counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-high (asserted when 1)
- rx_data  in  8  incoming stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte; always 1 after reset
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- bytes_loaded  out  8  payload bytes written in the current or last frame
- load_done  out  1  sticky: last frame good
- load_err  out  1  sticky: last frame failed
- core_run  out  1  equals load_done; enables core execution

Behaviour:
- Reset (rst_n=1, asynchronous):
  - state=IDLE
  - mem_we=0, mem_addr=0, mem_wdata=0
  - bytes_loaded=0, load_done=0, load_err=0, core_run=0
  - checksum accumulator=0, timeout counter=0
  - Reset mid-frame aborts the frame. Memory locations already written stay written; core_run stays 0 until a new good load.
- Byte acceptance: a byte is accepted when rx_valid=1 and rx_ready=1. rx_ready is tied 1 (no backpressure), so one byte can be accepted per cycle.
- Frame format: SYNC, LEN, LEN payload bytes, CSUM.
  - LEN must be in 1..DEPTH. LEN=0 or LEN>DEPTH is an error.
  - Frame is good when (LEN + sum of payload + CSUM) mod 256 == 0.
- State machine:
  - IDLE:
    - Accepted byte == SYNC: clear load_done, load_err, bytes_loaded and the checksum accumulator, then go to LEN.
    - Any other byte is discarded silently; load_done/load_err keep their values.
  - LEN:
    - Accepted byte in 1..DEPTH: store as length, checksum=byte, address counter=0, go to DATA.
    - Otherwise: load_err=1, go to IDLE.
  - DATA, for each accepted byte:
    - Registered output in the next cycle: mem_we=1, mem_addr=address counter, mem_wdata=byte.
    - Increment the address counter and bytes_loaded; add the byte into checksum (8-bit wrap).
    - After the LEN-th byte, go to CSUM.
  - CSUM, on the accepted byte:
    - If (checksum + byte) mod 256 == 0: load_done=1.
    - Otherwise: load_err=1.
    - Go to IDLE either way.
- mem_we timing: a 1-cycle pulse, latency exactly 1 cycle after acceptance. Back-to-back bytes give a consecutive strobe per byte. mem_addr/mem_wdata hold their last values when mem_we=0.
- Timeout (LEN, DATA, CSUM only):
  - Counter clears on every accepted byte and increments on every other cycle.
  - When it reaches TIMEOUT-1 with no byte in that cycle: load_err=1, go to IDLE.
  - A byte arriving in the same cycle as expiry wins; no error.
- Resync: a SYNC byte seen in LEN, DATA or CSUM is treated as data. There is no mid-frame resync.
- core_run: falls in the cycle after a SYNC is accepted in IDLE, and rises in the cycle after a good CSUM.
- All outputs are registered.

Test Plan:
- Good load: A5 03 01 05 0A ED →
  - mem_we pulses at addr 0,1,2 with data 01,05,0A, each 1 cycle after its byte
  - load_done=1, core_run=1, load_err=0, bytes_loaded=3
- Bad checksum: A5 03 01 05 0A EE →
  - three writes still occur
  - load_err=1, load_done=0, core_run=0
- Length errors: A5 00 → load_err=1, no writes. A5 81 → load_err=1, no writes, state IDLE.
- Timeout:
  - A5 02 11, then idle for TIMEOUT cycles → load_err=1, one write (addr 0 = 11).
  - Repeat with the next byte arriving exactly on the expiry cycle → no error.
- Reload: a good load (run=1), then 00 FF (garbage, ignored, run stays 1), then A5 → run=0 the next cycle.
  - Then a full 128-byte frame streamed back-to-back with correct CSUM → 128 consecutive mem_we pulses at addr 0..127, load_done=1, bytes_loaded=128.
- Async reset: assert rst_n during DATA (between clock edges) → all outputs 0 immediately. After release, A5 01 07 F8 → load_done=1.

Source files
------------

// File: rtl/prog_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : prog_loader_if
//  Brief    : Byte-stream input and instruction-memory write bundle of the
//             program loader, plus its load status outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface prog_loader_if #(
    parameter int ADDR_W = 7
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        bytes_loaded;
    logic              load_done;
    logic              load_err;
    logic              core_run;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata,
        input  bytes_loaded, load_done, load_err, core_run
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata,
        output bytes_loaded, load_done, load_err, core_run
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Brief    : Parses SYNC/LEN/payload/CSUM frames and writes the payload into
//             the core's instruction memory; enables the core on a good load.
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader #(
    parameter int         ADDR_W  = 7,
    parameter int         DEPTH   = 128,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 1000,
    parameter int         TO_W    = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    prog_loader_if.slave bus
);
    localparam logic [8:0]      c_DEPTH   = 9'(DEPTH);
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } state_t;

    state_t            state_q;
    logic [7:0]        len_q;
    logic [7:0]        sum_q;
    logic [7:0]        cnt_q;
    logic [7:0]        wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [TO_W-1:0]   to_q;
    logic              we_q;
    logic              done_q;
    logic              err_q;

    logic              w_acc;
    logic              w_len_ok;
    logic              w_expire;
    logic [7:0]        w_sum;
    logic [7:0]        w_cnt_nx;

    always_comb begin
        w_acc    = bus.rx_valid;
        w_sum    = sum_q + bus.rx_data;
        w_cnt_nx = cnt_q + 8'd1;
        w_len_ok = (bus.rx_data != 8'd0) && ({1'b0, bus.rx_data} <= c_DEPTH);
        // A byte landing on the expiry cycle takes priority over the abort.
        w_expire = (to_q == c_TO_LAST) && !w_acc;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            to_q    <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (state_q == S_IDLE) begin
                to_q <= '0;
                if (w_acc && (bus.rx_data == SYNC)) begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                    sum_q   <= '0;
                    state_q <= S_LEN;
                end
            end else if (w_expire) begin
                err_q   <= 1'b1;
                to_q    <= '0;
                state_q <= S_IDLE;
            end else if (!w_acc) begin
                to_q <= to_q + TO_W'(1);
            end else begin
                to_q <= '0;
                if (state_q == S_LEN) begin
                    if (w_len_ok) begin
                        len_q   <= bus.rx_data;
                        sum_q   <= bus.rx_data;
                        cnt_q   <= '0;
                        state_q <= S_DATA;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end else if (state_q == S_DATA) begin
                    we_q    <= 1'b1;
                    addr_q  <= cnt_q[ADDR_W-1:0];
                    wdata_q <= bus.rx_data;
                    cnt_q   <= w_cnt_nx;
                    sum_q   <= w_sum;
                    if (w_cnt_nx == len_q) begin
                        state_q <= S_CSUM;
                    end
                end else begin
                    if (w_sum == 8'd0) begin
                        done_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
            end
        end
    end

    assign bus.rx_ready     = 1'b1;
    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.bytes_loaded = cnt_q;
    assign bus.load_done    = done_q;
    assign bus.load_err     = err_q;
    assign bus.core_run     = done_q;
endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Brief    : Self-checking bench for prog_loader: directed frames plus
//             randomized frames compared against a frame-parsing model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;
    localparam int         ADDR_W  = 7;
    localparam int         DEPTH   = 128;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         TIMEOUT = 1000;
    localparam int         TO_W    = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .SYNC   (SYNC),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] stim[$];
    int         acc_cyc[$];
    int         obs_addr[$];
    int         obs_data[$];
    int         obs_cyc[$];
    int         exp_addr[$];
    int         exp_data[$];
    int         exp_idx[$];
    bit         exp_done;
    bit         exp_err;
    int         exp_bl;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            obs_addr.push_back(int'(bus.mem_addr));
            obs_data.push_back(int'(bus.mem_wdata));
            obs_cyc.push_back(cyc);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        stim.push_back(b);
        @(posedge clk);
        #1;
        acc_cyc.push_back(cyc);
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        stim.delete();
        acc_cyc.delete();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    // Frame parser: skip to SYNC, validate LEN, collect payload, check sum.
    function automatic void model_frame();
        int i = 0;
        int len;
        int sum;
        exp_addr.delete();
        exp_data.delete();
        exp_idx.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_bl   = 0;
        while (i < stim.size() && stim[i] != SYNC) i++;
        i++;
        if (i >= stim.size()) return;
        len = int'(stim[i]);
        i++;
        if (len < 1 || len > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        sum = len;
        for (int k = 0; k < len && i < stim.size(); k++) begin
            exp_addr.push_back(k);
            exp_data.push_back(int'(stim[i]));
            exp_idx.push_back(i);
            sum += int'(stim[i]);
            i++;
        end
        exp_bl = len;
        if (i < stim.size() && ((sum + int'(stim[i])) % 256) == 0) exp_done = 1'b1;
        else exp_err = 1'b1;
    endfunction

    task automatic test_reset();
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b want 0", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 7'd0) begin n_fail++; $display("FAIL rst_addr: got %0h want 0", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 8'd0) begin n_fail++; $display("FAIL rst_wdata: got %0h want 0", bus.mem_wdata); end
        n_cmp++; if (bus.bytes_loaded !== 8'd0) begin n_fail++; $display("FAIL rst_bl: got %0d want 0", bus.bytes_loaded); end
        n_cmp++; if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", bus.load_done); end
        n_cmp++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", bus.load_err); end
        n_cmp++; if (bus.core_run !== 1'b0) begin n_fail++; $display("FAIL rst_run: got %0b want 0", bus.core_run); end
        n_cmp++; if (bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", bus.rx_ready); end
    endtask

    task automatic test_good_load();
        logic [7:0] pd[3];
        pd[0] = 8'h01; pd[1] = 8'h05; pd[2] = 8'h0A;
        clear_logs();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
        send_byte(8'h05); send_byte(8'h0A); send_byte(8'hED);
        idle(2);
        n_cmp++; if (obs_addr.size() != 3) begin n_fail++; $display("FAIL good_nwr: got %0d want 3", obs_addr.size()); end
        for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
            n_cmp++; if (obs_addr[i] != i) begin n_fail++; $display("FAIL good_addr[%0d]: got %0d want %0d", i, obs_addr[i], i); end
            n_cmp++; if (obs_data[i] != int'(pd[i])) begin n_fail++; $display("FAIL good_data[%0d]: got %0h want %0h", i, obs_data[i], pd[i]); end
            n_cmp++; if (obs_cyc[i] != acc_cyc[2+i]) begin n_fail++; $display("FAIL good_lat[%0d]: got cyc %0d want %0d", i, obs_cyc[i], acc_cyc[2+i]); end
        end
        n_cmp++; if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL good_done: got %0b want 1", bus.load_done); end
        n_cmp++; if (bus.core_run !== 1'b1) begin n_fail++; $display("FAIL good_run: got %0b want 1", bus.core_run); end
        n_cmp++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL good_err: got %0b want 0", bus.load_err); end
        n_cmp++; if (bus.bytes_loaded !== 8'd3) begin n_fail++; $display("FAIL good_bl: got %0d want 3", bus.bytes_loaded); end
        n_cmp++; if (bus.mem_addr !== 7'd2 || bus.mem_wdata !== 8'h0A) begin n_fail++; $display("FAIL good_hold: got %0h/%0h want 2/0a", bus.mem_addr, bus.mem_wdata); end
    endtask

    task automatic test_bad_csum();
        clear_logs();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
        send_byte(8'h05); send_byte(8'h0A); send_byte(8'hEE);
        idle(2);
        n_cmp++; if (obs_addr.size() != 3) begin n_fail++; $display("FAIL badcs_nwr: got %0d want 3", obs_addr.size()); end
        n_cmp++; if (bus.load_err !== 1'b1) begin n_fail++; $display("FAIL badcs_err: got %0b want 1", bus.load_err); end
        n_cmp++; if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL badcs_done: got %0b want 0", bus.load_done); end
        n_cmp++; if (bus.core_run !== 1'b0) begin n_fail++; $display("FAIL badcs_run: got %0b want 0", bus.core_run); end
    endtask

    task automatic test_len_err();
        clear_logs();
        send_byte(8'hA5); send_byte(8'h00);
        idle(2);
        n_cmp++; if (bus.load_err !== 1'b1) begin n_fail++; $display("FAIL len0_err: got %0b want 1", bus.load_err); end
        n_cmp++; if (obs_addr.size() != 0) begin n_fail++; $display("FAIL len0_nwr: got %0d want 0", obs_addr.size()); end
        clear_logs();
        send_byte(8'hA5); send_byte(8'h81);
        idle(2);
        n_cmp++; if (bus.load_err !== 1'b1) begin n_fail++; $display("FAIL len81_err: got %0b want 1", bus.load_err); end
        n_cmp++; if (obs_addr.size() != 0) begin n_fail++; $display("FAIL len81_nwr: got %0d want 0", obs_addr.size()); end
        // Back in IDLE: a fresh frame must load cleanly.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'hF8);
        idle(1);
        n_cmp++; if (bus.load_done !== 1'b1 || bus.load_err !== 1'b0) begin n_fail++; $display("FAIL len81_idle: got done %0b err %0b want 1 0", bus.load_done, bus.load_err); end
    endtask

    task automatic test_timeout();
        clear_logs();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        idle(TIMEOUT - 1);
        n_cmp++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got err %0b want 0", bus.load_err); end
        idle(1);
        n_cmp++; if (bus.load_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %0b want 1", bus.load_err); end
        n_cmp++; if (obs_addr.size() != 1) begin n_fail++; $display("FAIL to_nwr: got %0d want 1", obs_addr.size()); end
        if (obs_addr.size() > 0) begin
            n_cmp++; if (obs_addr[0] != 0 || obs_data[0] != 8'h11) begin n_fail++; $display("FAIL to_wr: got %0d/%0h want 0/11", obs_addr[0], obs_data[0]); end
        end
        clear_logs();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        idle(TIMEOUT - 1);
        send_byte(8'h22);
        n_cmp++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL to_edge_err: got %0b want 0", bus.load_err); end
        send_byte(8'hCB);
        idle(1);
        n_cmp++; if (bus.load_done !== 1'b1 || bus.load_err !== 1'b0) begin n_fail++; $display("FAIL to_edge_done: got done %0b err %0b want 1 0", bus.load_done, bus.load_err); end
        n_cmp++; if (obs_addr.size() != 2) begin n_fail++; $display("FAIL to_edge_nwr: got %0d want 2", obs_addr.size()); end
    endtask

    task automatic test_reload_full();
        logic [7:0] pl[128];
        int sum;
        int first;
        clear_logs();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'hF8);
        idle(1);
        n_cmp++; if (bus.core_run !== 1'b1) begin n_fail++; $display("FAIL rl_run1: got %0b want 1", bus.core_run); end
        send_byte(8'h00); send_byte(8'hFF);
        idle(1);
        n_cmp++; if (bus.core_run !== 1'b1 || bus.load_err !== 1'b0) begin n_fail++; $display("FAIL rl_garbage: got run %0b err %0b want 1 0", bus.core_run, bus.load_err); end
        clear_logs();
        send_byte(8'hA5);
        n_cmp++; if (bus.core_run !== 1'b0) begin n_fail++; $display("FAIL rl_run0: got %0b want 0", bus.core_run); end
        sum = 128;
        for (int i = 0; i < 128; i++) begin
            pl[i] = 8'($urandom_range(0, 255));
            sum += int'(pl[i]);
        end
        bus.rx_data  = 8'h80;
        bus.rx_valid = 1'b1;
        stim.push_back(8'h80);
        @(posedge clk); #1; acc_cyc.push_back(cyc);
        for (int i = 0; i < 128; i++) begin
            bus.rx_data = pl[i];
            stim.push_back(pl[i]);
            @(posedge clk); #1; acc_cyc.push_back(cyc);
        end
        bus.rx_data = 8'((256 - (sum % 256)) % 256);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        idle(2);
        first = acc_cyc[2];
        n_cmp++; if (obs_addr.size() != 128) begin n_fail++; $display("FAIL full_nwr: got %0d want 128", obs_addr.size()); end
        for (int i = 0; i < 128 && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] != i || obs_data[i] != int'(pl[i]) || obs_cyc[i] != first + i) begin
                n_fail++;
                $display("FAIL full_wr[%0d]: got a%0d d%0h c%0d want a%0d d%0h c%0d", i, obs_addr[i], obs_data[i], obs_cyc[i], i, pl[i], first + i);
            end
        end
        n_cmp++; if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %0b want 1", bus.load_done); end
        n_cmp++; if (bus.bytes_loaded !== 8'd128) begin n_fail++; $display("FAIL full_bl: got %0d want 128", bus.bytes_loaded); end
    endtask

    task automatic test_async_reset();
        clear_logs();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
        #3;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 7'd0 || bus.mem_wdata !== 8'd0 || bus.bytes_loaded !== 8'd0 ||
            bus.load_done !== 1'b0 || bus.load_err !== 1'b0 || bus.core_run !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_outs: got we%0b a%0h d%0h bl%0d done%0b err%0b run%0b want all 0", bus.mem_we, bus.mem_addr,
                     bus.mem_wdata, bus.bytes_loaded, bus.load_done, bus.load_err, bus.core_run);
        end
        #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'hF8);
        idle(1);
        n_cmp++; if (bus.load_done !== 1'b1 || bus.core_run !== 1'b1) begin n_fail++; $display("FAIL arst_reload: got done %0b run %0b want 1 1", bus.load_done, bus.core_run); end
    endtask

    task automatic test_random();
        int kind;
        int len;
        int sum;
        logic [7:0] b;
        for (int f = 0; f < 12; f++) begin
            clear_logs();
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                idle($urandom_range(0, 3));
                send_byte(b);
            end
            kind = $urandom_range(0, 3);
            idle($urandom_range(0, 3));
            send_byte(SYNC);
            if (kind == 3) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(129, 255);
                idle($urandom_range(0, 3));
                send_byte(8'(len));
            end else begin
                len = ($urandom_range(0, 5) == 0) ? 128 : $urandom_range(1, 24);
                idle($urandom_range(0, 3));
                send_byte(8'(len));
                sum = len;
                for (int k = 0; k < len; k++) begin
                    b = (k == 0 && f[0]) ? SYNC : 8'($urandom_range(0, 255));
                    sum += int'(b);
                    idle($urandom_range(0, 3));
                    send_byte(b);
                end
                b = 8'((256 - (sum % 256)) % 256);
                if (kind == 2) b = b + 8'($urandom_range(1, 255));
                idle($urandom_range(0, 3));
                send_byte(b);
            end
            idle(2);
            model_frame();
            n_cmp++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL rnd%0d_nwr: got %0d want %0d", f, obs_addr.size(), exp_addr.size()); end
            for (int j = 0; j < exp_addr.size() && j < obs_addr.size(); j++) begin
                n_cmp++;
                if (obs_addr[j] != exp_addr[j] || obs_data[j] != exp_data[j] || obs_cyc[j] != acc_cyc[exp_idx[j]]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_wr[%0d]: got a%0d d%0h c%0d want a%0d d%0h c%0d", f, j, obs_addr[j], obs_data[j], obs_cyc[j],
                             exp_addr[j], exp_data[j], acc_cyc[exp_idx[j]]);
                end
            end
            n_cmp++; if (bus.load_done !== exp_done || bus.core_run !== exp_done) begin n_fail++; $display("FAIL rnd%0d_done: got %0b/%0b want %0b", f, bus.load_done, bus.core_run, exp_done); end
            n_cmp++; if (bus.load_err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err: got %0b want %0b", f, bus.load_err, exp_err); end
            n_cmp++; if (int'(bus.bytes_loaded) != exp_bl) begin n_fail++; $display("FAIL rnd%0d_bl: got %0d want %0d", f, bus.bytes_loaded, exp_bl); end
        end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b0;
        idle(2);
        test_reset();
        test_good_load();
        test_bad_csum();
        test_len_err();
        test_timeout();
        test_reload_full();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
